// File: rtl/depth_line_buffer.sv
// Ping-pong line buffer between the Mandelbrot line calculator and the
// colour-mapping stage: captures out-of-order (x, depth) writes for one line,
// requests the next line, and streams finished lines in raster order.
module depth_line_buffer #(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned DEPTH_WIDTH   = 10,
    localparam int unsigned XW = $clog2(SCREEN_WIDTH),
    localparam int unsigned YW = $clog2(SCREEN_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [XW-1:0]          wr_addr,
    input  logic [DEPTH_WIDTH-1:0] wr_depth,
    input  logic                   line_done,
    output logic                   line_start,
    output logic [DEPTH_WIDTH-1:0] m_depth,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   m_user,
    output logic [YW-1:0]          m_y,
    output logic                   err
);

    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);

    // Line storage, one RAM per bank
    logic [DEPTH_WIDTH-1:0] mem0 [SCREEN_WIDTH];
    logic [DEPTH_WIDTH-1:0] mem1 [SCREEN_WIDTH];

    // Write-side state
    logic       wb;
    logic       busy;
    logic [1:0] bank_full;

    // Read-side state
    logic          rb;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          issued_all;

    // RAM output stage (doubles as the prefetch skid entry)
    logic [DEPTH_WIDTH-1:0] ram_q;
    logic                   s1_valid;
    logic                   s1_last;
    logic                   s1_user;
    logic [YW-1:0]          s1_y;

    // Combinational strobes
    logic          wr_ok_c;
    logic          wr_err_c;
    logic          commit_c;
    logic          done_err_c;
    logic          release_c;
    logic          rd_bank_c;
    logic [YW-1:0] y_next_c;
    logic [YW-1:0] rd_y_c;
    logic          s1_move_c;
    logic          issue_c;
    logic [1:0]    bank_full_nx_c;

    // Decode write/commit legality, bank hand-over and read issue
    always_comb begin
        wr_ok_c        = wr_en && busy && (wr_addr <= X_LAST);
        wr_err_c       = wr_en && !wr_ok_c;
        commit_c       = line_done && busy;
        done_err_c     = line_done && !busy;
        release_c      = m_valid && m_ready && m_last;
        y_next_c       = (rd_y == Y_LAST) ? '0 : rd_y + 1'b1;
        // On the release edge the read side already looks at the other bank,
        // so a full successor line starts with only the RAM latency as gap.
        rd_bank_c      = rb ^ release_c;
        rd_y_c         = release_c ? y_next_c : rd_y;
        s1_move_c      = s1_valid && (!m_valid || m_ready);
        issue_c        = bank_full[rd_bank_c] && !(issued_all && !release_c) &&
                         (!s1_valid || s1_move_c);
        bank_full_nx_c = bank_full;
        if (release_c) bank_full_nx_c[rb] = 1'b0;
        if (commit_c)  bank_full_nx_c[wb] = 1'b1;
    end

    // RAM write port
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            if (wb) mem1[wr_addr] <= wr_depth;
            else    mem0[wr_addr] <= wr_depth;
        end
    end

    // RAM read port, 1-cycle latency; holds its data while stalled
    always_ff @(posedge clk) begin
        if (issue_c) ram_q <= rd_bank_c ? mem1[rd_x] : mem0[rd_x];
    end

    // Write-side control: line requests, commits and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wb         <= 1'b0;
            busy       <= 1'b0;
            bank_full  <= 2'b00;
            line_start <= 1'b0;
            err        <= 1'b0;
        end else begin
            line_start <= 1'b0;
            bank_full  <= bank_full_nx_c;
            err        <= err | wr_err_c | done_err_c;
            if (commit_c) begin
                busy <= 1'b0;
                wb   <= ~wb;
            end else if (!busy && !bank_full[wb]) begin
                busy       <= 1'b1;
                line_start <= 1'b1;
            end
        end
    end

    // Read-side control: address generation, bank release, line counter
    always_ff @(posedge clk) begin
        if (reset) begin
            rb         <= 1'b0;
            rd_x       <= '0;
            rd_y       <= '0;
            issued_all <= 1'b0;
        end else begin
            if (release_c) begin
                rb   <= ~rb;
                rd_y <= y_next_c;
            end
            if (issue_c) begin
                rd_x       <= (rd_x == X_LAST) ? '0 : rd_x + 1'b1;
                issued_all <= (rd_x == X_LAST);
            end else if (release_c) begin
                issued_all <= 1'b0;
            end
        end
    end

    // Sideband tracking alongside the RAM output
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_user  <= 1'b0;
            s1_y     <= '0;
        end else if (issue_c) begin
            s1_valid <= 1'b1;
            s1_last  <= (rd_x == X_LAST);
            s1_user  <= (rd_x == '0) && (rd_y_c == '0);
            s1_y     <= rd_y_c;
        end else if (s1_move_c) begin
            s1_valid <= 1'b0;
        end
    end

    // Output register: loads when empty or when its beat is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_depth <= '0;
            m_last  <= 1'b0;
            m_user  <= 1'b0;
            m_y     <= '0;
        end else if (s1_move_c) begin
            m_valid <= 1'b1;
            m_depth <= ram_q;
            m_last  <= s1_last;
            m_user  <= s1_user;
            m_y     <= s1_y;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
